// File: rtl/rd_pkg.sv
// Shared defaults and helpers for the read-side prefetch buffer.
package rd_pkg;

    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned PF_DEPTH_DEF  = 4;
    localparam int unsigned AE_THRESH_DEF = 1;

    // Width needed to count 0..depth inclusive.
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rd_prefetch_buffer_if.sv
// Upstream FIFO read port and downstream valid/ready stream of the prefetch buffer.
interface rd_prefetch_buffer_if
    import rd_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned PF_DEPTH = PF_DEPTH_DEF
);
    localparam int unsigned LW = level_w(PF_DEPTH);

    logic              fifoEmpty;
    logic              rdEn;
    logic [DATA_W-1:0] dout;
    logic              flush;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [LW-1:0]     level;
    logic              m_almostEmpty;

    modport slave (
        input  fifoEmpty, dout, flush, m_ready,
        output rdEn, m_valid, m_data, level, m_almostEmpty
    );

    modport master (
        output fifoEmpty, dout, flush, m_ready,
        input  rdEn, m_valid, m_data, level, m_almostEmpty
    );

endinterface

// File: rtl/rd_pf_ram.sv
// Prefetch storage: synchronous write, asynchronous read, no reset.
module rd_pf_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/rd_prefetch_buffer.sv
// Prefetches words from an upstream FIFO (one-cycle read latency) into a small
// circular buffer and presents them on a valid/ready stream.
module rd_prefetch_buffer
    import rd_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned PF_DEPTH  = PF_DEPTH_DEF,
    parameter int unsigned AE_THRESH = AE_THRESH_DEF
) (
    input logic                  rdClk,
    input logic                  rst,
    rd_prefetch_buffer_if.slave  bus
);

    localparam int unsigned LW = level_w(PF_DEPTH);
    localparam int unsigned PW = $clog2(PF_DEPTH);

    logic [LW-1:0]     level_q, level_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic              inflight_q, inflight_d;
    logic              pop, pop_eff, rd_en, wr_en;
    logic [LW:0]       occ;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        pop     = (level_q != '0) && bus.m_ready;
        pop_eff = pop && !bus.flush;
        // Words held plus the one on its way, less the one leaving this cycle.
        occ     = {1'b0, level_q} + (LW+1)'(inflight_q) - (LW+1)'(pop);
        rd_en   = !rst && !bus.flush && !bus.fifoEmpty && (occ < (LW+1)'(PF_DEPTH));
        wr_en   = inflight_q && !bus.flush && !rst;

        inflight_d = rd_en;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        if (wr_en) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop_eff) begin
            rptr_d = rptr_q + PW'(1);
        end
        level_d = level_q + LW'(wr_en) - LW'(pop_eff);

        if (bus.flush) begin
            level_d    = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge rdClk) begin
        if (rst) begin
            level_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            level_q    <= level_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
        end
    end

    rd_pf_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (PF_DEPTH)
    ) u_ram (
        .clk_i   (rdClk),
        .we_i    (wr_en),
        .waddr_i (wptr_q),
        .wdata_i (bus.dout),
        .raddr_i (rptr_q),
        .rdata_o (ram_rdata)
    );

    assign bus.rdEn          = rd_en;
    assign bus.m_valid       = (level_q != '0);
    assign bus.m_data        = ram_rdata;
    assign bus.level         = level_q;
    assign bus.m_almostEmpty = (level_q <= LW'(AE_THRESH));

endmodule

// File: tb/tb_rd_prefetch_buffer.sv
// Scoreboard bench: a queue model of the buffer contents plus a pending-word flag
// is advanced by the stimulus; a separate monitor compares DUT outputs against it.
module tb_rd_prefetch_buffer;
    import rd_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned AE = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rd_prefetch_buffer_if #(.DATA_W(DW), .PF_DEPTH(D)) bus ();

    rd_prefetch_buffer #(
        .DATA_W    (DW),
        .PF_DEPTH  (D),
        .AE_THRESH (AE)
    ) dut (
        .rdClk (clk),
        .rst   (rst),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [DW-1:0] exp_q[$];
    bit          pend;
    logic [DW-1:0] pend_word;
    bit          rden_exp;
    bit          mon_en;
    bit          use_seq;
    logic [DW-1:0] seq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle: drive inputs, predict rdEn, then advance the model at the edge.
    task automatic cycle(input bit r, input bit f, input bit fe, input bit mr);
        int held;
        @(negedge clk);
        rst           = r;
        bus.flush     = f;
        bus.fifoEmpty = fe;
        bus.m_ready   = mr;
        #1;
        held     = exp_q.size() + int'(pend) - ((exp_q.size() != 0 && mr) ? 1 : 0);
        rden_exp = !r && !f && !fe && (held < int'(D));
        @(posedge clk);
        #1;
        if (r || f) begin
            exp_q.delete();
            pend = 1'b0;
        end else begin
            if (pend) exp_q.push_back(pend_word);
            pend = rden_exp;
        end
        pend_word = use_seq ? seq : DW'($urandom);
        if (use_seq && rden_exp) seq++;
        bus.dout = pend_word;
    endtask

    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            check("rdEn", bus.rdEn, rden_exp);
            check("level", bus.level, exp_q.size());
            check("m_valid", bus.m_valid, exp_q.size() != 0);
            check("m_almostEmpty", bus.m_almostEmpty, exp_q.size() <= AE);
            if (bus.m_valid === 1'b1 && exp_q.size() != 0) begin
                check("m_data", bus.m_data, exp_q[0]);
                if (bus.m_ready && !bus.flush && !rst) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int mr_pct;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.fifoEmpty = 1'b1;
        bus.m_ready   = 1'b0;
        bus.dout      = '0;
        pend          = 1'b0;
        pend_word     = '0;
        rden_exp      = 1'b0;
        use_seq       = 1'b1;
        seq           = 8'h11;
        mon_en        = 1'b0;

        cycle(1, 0, 1, 0);
        mon_en = 1'b1;
        cycle(1, 0, 0, 0);

        // Fill with consumer stalled, then stream.
        repeat (8) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        seq = 8'h11;
        repeat (12) cycle(0, 0, 0, 1);

        // Full buffer with alternating consumer, across pointer wrap.
        repeat (6) cycle(0, 0, 0, 0);
        for (int i = 0; i < 14; i++) cycle(0, 0, 0, i[0]);

        // Flush the cycle after rdEn from empty.
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        repeat (3) cycle(0, 0, 1, 0);

        // Upstream empty throughout.
        repeat (6) cycle(0, 0, 1, 1);

        // Reset with level 3 and a word in flight.
        repeat (4) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        repeat (3) cycle(0, 0, 1, 0);
        repeat (4) cycle(0, 0, 0, 1);

        use_seq = 1'b0;
        for (int blk = 0; blk < 20; blk++) begin
            mr_pct = $urandom_range(10, 90);
            repeat (150) begin
                cycle($urandom_range(0, 99) == 0,
                      $urandom_range(0, 29) == 0,
                      $urandom_range(0, 3) == 0,
                      $urandom_range(0, 99) < mr_pct);
            end
        end

        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rd_prefetch_buffer.md
RD_PREFETCH_BUFFER -- requirements
Module: rd_prefetch_buffer

Interface
REQ-001 Parameter DATA_W, default 8: width of dout and m_data.
REQ-002 Parameter PF_DEPTH, default 4: prefetch entries; power of two, 2..16.
REQ-003 Parameter AE_THRESH, default 1: m_almostEmpty asserts when level <= AE_THRESH; range 0..PF_DEPTH-1.
REQ-004 Clocking: one clock, rdClk; reset rst is synchronous and active-high.
REQ-005 rdClk  in  1  clock; every register updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 fifoEmpty  in  1  upstream FIFO holds no data.
REQ-008 rdEn  out  1  upstream read request; one word per cycle asserted.
REQ-009 dout  in  DATA_W  upstream read data, valid the cycle after an accepted rdEn.
REQ-010 flush  in  1  discard all buffered and in-flight words.
REQ-011 m_valid  out  1  m_data holds a valid word.
REQ-012 m_ready  in  1  consumer accepts m_data this cycle.
REQ-013 m_data  out  DATA_W  head-of-buffer word.
REQ-014 level  out  $clog2(PF_DEPTH+1)  words currently buffered.
REQ-015 m_almostEmpty  out  1  level <= AE_THRESH.

Function
REQ-016 Pop occurs in a cycle with m_valid=1 and m_ready=1; m_data SHALL be stable while m_valid=1 and m_ready=0.
REQ-017 rdEn = !rst && !flush && !fifoEmpty && (level + inflight - pop) < PF_DEPTH; combinational, depends on m_ready through pop.
REQ-018 rdEn SHALL never assert while fifoEmpty=1; no upstream underflow is possible.
REQ-019 inflight register SHALL be set to 1 at an edge where rdEn=1, else cleared.
REQ-020 At an edge with inflight=1 and no flush, dout SHALL be written at the write pointer and level incremented, unless a pop occurs in the same cycle, in which case level is unchanged.
REQ-021 Latency: rdEn high in cycle N -> word stored at edge N+1 -> m_valid high in cycle N+2 when the buffer was empty.
REQ-022 Sustained throughput: one word per cycle when fifoEmpty=0 and m_ready=1.
REQ-023 Storage is circular; read and write pointers are $clog2(PF_DEPTH) bits and wrap from PF_DEPTH-1 to 0.
REQ-024 m_valid = (level != 0), from registered state only.
REQ-025 level SHALL never exceed PF_DEPTH; write-while-full SHALL not occur by construction of REQ-017.
REQ-026 flush: at the edge, level, pointers and inflight cleared; a word arriving at that edge or at the following edge from a read issued before flush SHALL be dropped.
REQ-027 flush and a pop in the same cycle: flush wins; pop has no effect.
REQ-028 m_almostEmpty SHALL be derived from registered level.

Reset
REQ-029 Under rst: rdEn=0, m_valid=0, level=0, m_almostEmpty=1, inflight=0, pointers=0; m_data value is don't-care.
REQ-030 rst asserted mid-transfer SHALL discard any in-flight word; the first rdEn is possible in the first cycle after rst deasserts.

Structure
REQ-031 Shared package rd_pkg SHALL hold default DATA_W, PF_DEPTH, AE_THRESH and a level-width function.
REQ-032 Storage SHALL be a sub-module rd_pf_ram: PF_DEPTH x DATA_W, one synchronous write port, one asynchronous read port, no reset.

Verification
REQ-033 Reset then fifoEmpty=0, m_ready=0, PF_DEPTH=4 -> rdEn high 4 cycles, level 1,2,3,4, then rdEn=0, m_valid=1.
REQ-034 Upstream words 0x11..0x18, m_ready=1 -> m_data 0x11..0x18 in order, one per cycle from cycle 2, no gaps.
REQ-035 Buffer full, m_ready toggles 1/0 -> rdEn mirrors pop cycles, level held at 3..4, data order preserved across pointer wrap.
REQ-036 flush asserted the cycle after rdEn -> word arriving next edge dropped, level=0, m_valid=0, m_almostEmpty=1.
REQ-037 fifoEmpty=1 throughout with m_ready=1 -> rdEn never asserts, m_valid stays 0.
REQ-038 rst asserted with level=3 and inflight=1 -> next cycle all outputs at reset values, no stale word appears after release.
